// File: rtl/rally_sequencer.sv
// Ping-pong game controller: serve/rally/done sequencing, scoring, countdown clock
// and serve arbitration. All outputs are registered.
//   state   | meaning
//   S_SERVE | ball parked on server's paddle, waiting for pause expiry and serve press
//   S_PLAY  | rally in progress, clock running, point detection active
//   S_DONE  | game over, everything frozen until reset
module rally_sequencer #(
    parameter int         WIN_SCORE     = 7,
    parameter int         GAME_TIME     = 60,
    parameter int         TICKS_PER_SEC = 60,
    parameter logic [9:0] TOP_LIMIT     = 10'd8,
    parameter logic [9:0] BOTTOM_LIMIT  = 10'd472,
    parameter int         PAUSE_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       p1_serve,
    input  logic       p2_serve,
    input  logic [9:0] ball_y,
    output logic [1:0] game_state,
    output logic       server,
    output logic       ball_hold,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [5:0] time_cnt,
    output logic [1:0] winner
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int PAU_W = (PAUSE_FRAMES > 0) ? $clog2(PAUSE_FRAMES + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [PAU_W-1:0] PAUSE_INIT = PAU_W'(PAUSE_FRAMES);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
    localparam logic [5:0]       TIME_INIT  = 6'(GAME_TIME);

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_PLAY  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               server_q, server_d;
    logic               hold_q, hold_d;
    logic [3:0]         p1_q, p1_d, p2_q, p2_d;
    logic [5:0]         time_q, time_d;
    logic [1:0]         winner_q, winner_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [PAU_W-1:0]   pause_q, pause_d;
    logic               prev1_q, prev2_q, arm1_q, arm2_q;
    logic               edge1, edge2, srv_edge, pt1, pt2, wrap, time_out;

    // arm gates edges until the button has been seen released since reset
    assign edge1    = p1_serve & ~prev1_q & arm1_q;
    assign edge2    = p2_serve & ~prev2_q & arm2_q;
    assign srv_edge = server_q ? edge2 : edge1;
    assign pt1      = ball_y < TOP_LIMIT;
    assign pt2      = !pt1 && (ball_y > BOTTOM_LIMIT);
    assign wrap     = frame_tick && (pre_q == PRE_LAST);

    always_comb begin
        state_d  = state_q;
        server_d = server_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        time_d   = time_q;
        winner_d = 2'd0;
        pre_d    = pre_q;
        pause_d  = pause_q;
        time_out = 1'b0;
        case (state_q)
            S_SERVE: begin
                if (frame_tick && pause_q != '0)
                    pause_d = pause_q - PAU_W'(1);
                if (pause_q == '0 && srv_edge)
                    state_d = S_PLAY;
            end
            S_PLAY: begin
                if (frame_tick)
                    pre_d = wrap ? '0 : pre_q + PRE_W'(1);
                if (wrap && time_q != 6'd0) begin
                    time_d   = time_q - 6'd1;
                    time_out = (time_q == 6'd1);
                end
                if (pt1 && p1_q < WIN) begin
                    p1_d     = p1_q + 4'd1;
                    server_d = 1'b1;
                end else if (pt2 && p2_q < WIN) begin
                    p2_d     = p2_q + 4'd1;
                    server_d = 1'b0;
                end
                // a point landing with the last second is credited before the game ends
                if (p1_d == WIN || p2_d == WIN || time_out) begin
                    state_d  = S_DONE;
                    winner_d = (p1_d > p2_d) ? 2'd1 : (p2_d > p1_d) ? 2'd2 : 2'd3;
                end else if (pt1 || pt2) begin
                    state_d = S_SERVE;
                    pause_d = PAUSE_INIT;
                end
            end
            S_DONE:  winner_d = winner_q;
            default: state_d = S_SERVE;
        endcase
        hold_d = (state_d != S_PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_SERVE;
            server_q <= 1'b0;
            hold_q   <= 1'b1;
            p1_q     <= 4'd0;
            p2_q     <= 4'd0;
            time_q   <= TIME_INIT;
            winner_q <= 2'd0;
            pre_q    <= '0;
            pause_q  <= '0;
            prev1_q  <= 1'b0;
            prev2_q  <= 1'b0;
            arm1_q   <= 1'b0;
            arm2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            server_q <= server_d;
            hold_q   <= hold_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            time_q   <= time_d;
            winner_q <= winner_d;
            pre_q    <= pre_d;
            pause_q  <= pause_d;
            prev1_q  <= p1_serve;
            prev2_q  <= p2_serve;
            arm1_q   <= arm1_q | ~p1_serve;
            arm2_q   <= arm2_q | ~p2_serve;
        end
    end

    assign game_state = state_q;
    assign server     = server_q;
    assign ball_hold  = hold_q;
    assign p1_score   = p1_q;
    assign p2_score   = p2_q;
    assign time_cnt   = time_q;
    assign winner     = winner_q;

endmodule

// File: doc/rally_sequencer.md
Name: rally_sequencer

Overview:
Top-level game controller for the ping-pong design. Sequences serve, rally and game-over phases; detects points from the ball's vertical position; keeps both scores and the countdown clock; decides who serves. Drives the game_state bus consumed by the paddle, ball, timer-display and dot-matrix blocks. Player 1 defends the bottom edge (large y); player 2 defends the top edge.

Parameters:
WIN_SCORE, 7, points that end the game (1..15)
GAME_TIME, 60, countdown start value in seconds (1..63)
TICKS_PER_SEC, 60, frame_tick pulses per second
TOP_LIMIT, 10'd8, ball_y below this value scores for player 1
BOTTOM_LIMIT, 10'd472, ball_y above this value scores for player 2
PAUSE_FRAMES, 30, frame ticks after a point during which serves are ignored

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per video frame
p1_serve  input  1  player 1 serve button, debounced, level
p2_serve  input  1  player 2 serve button, debounced, level
ball_y  input  10  current ball vertical position
game_state  output  2  0=serve, 1=playing, 2=done (3 never driven)
server  output  1  0=player 1 serves, 1=player 2 serves
ball_hold  output  1  1: ball block parks the ball on the server's paddle
p1_score  output  4  player 1 points
p2_score  output  4  player 2 points
time_cnt  output  6  seconds remaining
winner  output  2  0=none, 1=p1, 2=p2, 3=draw

Behaviour:
- All outputs are registered. Each state change takes effect on the clk edge after the qualifying input cycle.
- Reset: game_state=0, server=0, ball_hold=1, scores=0, time_cnt=GAME_TIME, winner=0. Prescaler, pause counter and button-edge registers clear. Reset mid-game aborts immediately; no partial state survives.
- Serve edges: internal registers sample p1_serve/p2_serve. An edge is (now & !prev). A button held through reset does not produce an edge until it is released and pressed again.
- SERVE (0): ball_hold=1. Clock frozen and prescaler held, not cleared. pause_cnt decrements on each frame_tick while nonzero. If pause_cnt==0 and the current server's button edge occurs, go to PLAYING. The non-server's button is ignored.
- PLAYING (1): ball_hold=0.
  - Prescaler counts frame_tick pulses 0..TICKS_PER_SEC-1. On the wrapping tick, time_cnt decrements, saturating at 0.
  - ball_y < TOP_LIMIT: p1_score+1. ball_y > BOTTOM_LIMIT: p2_score+1. Either condition is a point.
  - After a point: server = the player who conceded, pause_cnt = PAUSE_FRAMES, go to SERVE.
  - Point detection is only active in PLAYING, so a ball still out of bounds next cycle scores once only.
- Game end:
  - If a score reaches WIN_SCORE, go to DONE instead of SERVE.
  - If time_cnt becomes 0 (the decrement from 1), go to DONE.
  - If a point and the final decrement happen in the same cycle, the point is credited first, then the state goes to DONE.
- DONE (2): ball_hold=1. Scores, time_cnt and server are frozen; all buttons are ignored. Stays until reset.
  - winner is written on the edge that enters DONE: higher score wins; equal scores give 3.
  - winner is 0 in every other state.
- Scores never exceed WIN_SCORE. time_cnt never wraps below 0.

Test Plan:
1. Reset, then p1_serve edge with pause_cnt=0 -> next cycle game_state=1, ball_hold=0. p2_serve edge while server=0 -> no change.
2. In PLAYING, drive ball_y=5 for 3 cycles -> p1_score=1 (exactly once), game_state=0, server=1. p2_serve edges ignored for 30 frame_ticks; the first edge after that -> PLAYING.
3. Bench overrides TICKS_PER_SEC=2, GAME_TIME=3; play with ball_y=240 -> time_cnt steps 3,2,1,0 every 2 ticks, then game_state=2. With scores 0/0 -> winner=3. Ticks in SERVE do not decrement time_cnt.
4. Alternate points until p2_score=7 with p1_score=4 (ball_y=480) -> game_state=2, winner=2, p2_score stays 7. Further serves and ball_y changes -> no change.
5. Same cycle: ball_y=480 and the final second tick with scores 2/2 -> p2_score=3, time_cnt=0, game_state=2, winner=2.
6. Hold p1_serve high across reset deassertion -> stays in SERVE. Release then press -> PLAYING. Assert reset mid-rally -> all outputs return to reset values next edge.
